// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream handshake, instruction-memory write port and
// load status of the program loader, grouped for one connection point.
// The loader connects through the slave modport; the host/byte source and
// the instruction ROM side use the master modport.
interface instr_loader_if #(
  parameter int ADDR_W = 10
);
  logic              Start;
  logic [7:0]        InByte;
  logic              InValid;
  logic              InReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [8:0]        WrData;
  logic              Loading;
  logic              Done;
  logic [1:0]        ErrCode;
  logic [ADDR_W:0]   Count;

  modport master (
    output Start, InByte, InValid,
    input  InReady, WrEn, WrAddr, WrData, Loading, Done, ErrCode, Count
  );

  modport slave (
    input  Start, InByte, InValid,
    output InReady, WrEn, WrAddr, WrData, Loading, Done, ErrCode, Count
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a byte stream (high byte first, only bit0 of the high
// byte used) into 9-bit instruction words and writes them to consecutive
// instruction-memory addresses from 0 until the Ack word 9'h1FF is written.
// Errors: 1 = reserved high-byte bits set, 2 = address space exhausted,
// 3 = checksum mismatch.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte
// (running XOR of all instruction bytes) that is verified in state CHK.
module instr_loader #(
  parameter int ADDR_W = 10
) (
  input logic           Clk,
  input logic           Reset,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [8:0]        ACK_WORD   = 9'h1FF;

`ifdef LOADER_CHECKSUM_EN
  // Running checksum update: XOR accumulation of one instruction byte.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic              hi_bit_r, hi_bit_s;
  logic [1:0]        err_r, err_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [8:0]        wr_data_r, wr_data_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_r, csum_s;
`endif
  logic              in_ready_s;
  logic              loading_s;
  logic              xfer_s;
  logic [8:0]        word_s;

  assign xfer_s = bus.InValid & in_ready_s;
  assign word_s = {hi_bit_r, bus.InByte};

  // Handshake readiness and busy flag decoded from the current state; Start blocks any byte.
  always_comb begin
    in_ready_s = 1'b0;
    loading_s  = 1'b0;
    case (state_r)
      ST_HI, ST_LO: loading_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:       loading_s = 1'b1;
`endif
      default:      loading_s = 1'b0;
    endcase
    if (bus.Start) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = loading_s;
    end
  end

  // Next-state and next-register computation for the load sequencer.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    count_s   = count_r;
    hi_bit_s  = hi_bit_r;
    err_s     = err_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
`ifdef LOADER_CHECKSUM_EN
    csum_s    = csum_r;
`endif
    if (bus.Start) begin
      // Restart from any state; a half-received word is simply dropped.
      state_s  = ST_HI;
      addr_s   = ADDR_ZERO;
      count_s  = COUNT_ZERO;
      hi_bit_s = 1'b0;
      err_s    = 2'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_s   = 8'h00;
`endif
    end else begin
      case (state_r)
        ST_HI: begin
          if (xfer_s) begin
            if (bus.InByte[7:1] != 7'd0) begin
              state_s = ST_ERR;
              err_s   = 2'd1;
            end else begin
              hi_bit_s = bus.InByte[0];
              state_s  = ST_LO;
`ifdef LOADER_CHECKSUM_EN
              csum_s   = csum_fold(csum_r, bus.InByte);
`endif
            end
          end else begin
            state_s = ST_HI;
          end
        end
        ST_LO: begin
          if (xfer_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr_r;
            wr_data_s = word_s;
            count_s   = count_r + COUNT_ONE;
`ifdef LOADER_CHECKSUM_EN
            csum_s    = csum_fold(csum_r, bus.InByte);
`endif
            // Ack has priority over overflow: the last address may hold Ack.
            if (word_s == ACK_WORD) begin
`ifdef LOADER_CHECKSUM_EN
              state_s = ST_CHK;
`else
              state_s = ST_DONE;
`endif
            end else if (addr_r == ADDR_MAX) begin
              state_s = ST_ERR;
              err_s   = 2'd2;
            end else begin
              addr_s  = addr_r + ADDR_ONE;
              state_s = ST_HI;
            end
          end else begin
            state_s = ST_LO;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer_s) begin
            if (bus.InByte == csum_r) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_ERR;
              err_s   = 2'd3;
            end
          end else begin
            state_s = ST_CHK;
          end
        end
`endif
        ST_IDLE, ST_DONE, ST_ERR: state_s = state_r;
        default:                  state_s = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      addr_r    <= ADDR_ZERO;
      count_r   <= COUNT_ZERO;
      hi_bit_r  <= 1'b0;
      err_r     <= 2'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= ADDR_ZERO;
      wr_data_r <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r    <= 8'h00;
`endif
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      count_r   <= count_s;
      hi_bit_r  <= hi_bit_s;
      err_r     <= err_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
`ifdef LOADER_CHECKSUM_EN
      csum_r    <= csum_s;
`endif
    end
  end

  assign bus.InReady = in_ready_s;
  assign bus.WrEn    = wr_en_r;
  assign bus.WrAddr  = wr_addr_r;
  assign bus.WrData  = wr_data_r;
  assign bus.Loading = loading_s;
  assign bus.Done    = (state_r == ST_DONE);
  assign bus.ErrCode = err_r;
  assign bus.Count   = count_r;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven directed vectors for a 10-bit-address loader
// plus a hand-written overflow sequence on a 2-bit-address loader.
// Works with and without LOADER_CHECKSUM_EN defined.
module tb_instr_loader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cur_row;

  instr_loader_if #(.ADDR_W(10)) bus_a ();
  instr_loader_if #(.ADDR_W(2))  bus_b ();

  instr_loader #(.ADDR_W(10)) dut_a (.Clk(clk), .Reset(rst), .bus(bus_a));
  instr_loader #(.ADDR_W(2))  dut_b (.Clk(clk), .Reset(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       e_ready;
    logic       e_wren;
    logic [9:0] e_addr;
    logic [8:0] e_wdata;
    logic       e_load;
    logic       e_done;
    logic [1:0] e_err;
    logic [10:0] e_count;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [9:0] a, input logic [8:0] wd,
                     input logic ld, input logic dn, input logic [1:0] er, input logic [10:0] cn);
    vec_t x;
    x.rst = r; x.start = s; x.valid = v; x.data = d;
    x.e_ready = rdy; x.e_wren = we; x.e_addr = a; x.e_wdata = wd;
    x.e_load = ld; x.e_done = dn; x.e_err = er; x.e_count = cn;
    vecs.push_back(x);
  endtask

  // Drive one cycle on loader B and return after the edge has been sampled.
  task automatic b_cycle(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus_b.Start = s; bus_b.InValid = v; bus_b.InByte = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; cur_row = 0;
    rst = 1'b1;
    bus_a.Start = 1'b0; bus_a.InValid = 1'b0; bus_a.InByte = 8'h00;
    bus_b.Start = 1'b0; bus_b.InValid = 1'b0; bus_b.InByte = 8'h00;

    // reset state, then idle ignores bytes
    add(1'b1,1'b0,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
    // basic load 00,A5 01,23 01,FF
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'hA5, 1'b1, 1'b1,10'd0,9'h0A5, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b0,8'h77, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'h23, 1'b1, 1'b1,10'd1,9'h123, 1'b1,1'b0,2'd0,11'd2);
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd2);
`ifdef LOADER_CHECKSUM_EN
    add(1'b0,1'b0,1'b1,8'hFF, 1'b1, 1'b1,10'd2,9'h1FF, 1'b1,1'b0,2'd0,11'd3);
    add(1'b0,1'b0,1'b1,8'h79, 1'b1, 1'b0,10'd0,9'h000, 1'b0,1'b1,2'd0,11'd3);
`else
    add(1'b0,1'b0,1'b1,8'hFF, 1'b1, 1'b1,10'd2,9'h1FF, 1'b0,1'b1,2'd0,11'd3);
`endif
    add(1'b0,1'b0,1'b1,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b1,2'd0,11'd3);
    // format error on first high byte 04
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h04, 1'b1, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd1,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd1,11'd0);
    // Start with InValid in LO discards the partial word
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'hA5, 1'b1, 1'b1,10'd0,9'h0A5, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b1,1'b1,8'h01, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h23, 1'b1, 1'b1,10'd0,9'h123, 1'b1,1'b0,2'd0,11'd1);
    // Reset together with a pending low byte: no write issued
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b1,1'b0,1'b1,8'hA5, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
    // Reset the cycle after a low-byte transfer clears the registered WrEn
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h3C, 1'b1, 1'b1,10'd0,9'h03C, 1'b1,1'b0,2'd0,11'd1);
    add(1'b1,1'b0,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd0,11'd0);
`ifdef LOADER_CHECKSUM_EN
    // checksum good (5B) and bad (5A)
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'hA5, 1'b1, 1'b1,10'd0,9'h0A5, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'hFF, 1'b1, 1'b1,10'd1,9'h1FF, 1'b1,1'b0,2'd0,11'd2);
    add(1'b0,1'b0,1'b1,8'h5B, 1'b1, 1'b0,10'd0,9'h000, 1'b0,1'b1,2'd0,11'd2);
    add(1'b0,1'b1,1'b0,8'h00, 1'b0, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'h00, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd0);
    add(1'b0,1'b0,1'b1,8'hA5, 1'b1, 1'b1,10'd0,9'h0A5, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'h01, 1'b1, 1'b0,10'd0,9'h000, 1'b1,1'b0,2'd0,11'd1);
    add(1'b0,1'b0,1'b1,8'hFF, 1'b1, 1'b1,10'd1,9'h1FF, 1'b1,1'b0,2'd0,11'd2);
    add(1'b0,1'b0,1'b1,8'h5A, 1'b1, 1'b0,10'd0,9'h000, 1'b0,1'b0,2'd3,11'd2);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row = i;
      @(negedge clk);
      rst = vecs[i].rst;
      bus_a.Start = vecs[i].start;
      bus_a.InValid = vecs[i].valid;
      bus_a.InByte = vecs[i].data;
      #1;
      if (!vecs[i].rst) check("in_ready", {31'd0, bus_a.InReady}, {31'd0, vecs[i].e_ready});
      @(posedge clk);
      #1;
      check("wr_en",   {31'd0, bus_a.WrEn},    {31'd0, vecs[i].e_wren});
      if (vecs[i].e_wren || vecs[i].rst) begin
        check("wr_addr", {22'd0, bus_a.WrAddr}, {22'd0, vecs[i].e_addr});
        check("wr_data", {23'd0, bus_a.WrData}, {23'd0, vecs[i].e_wdata});
      end
      check("loading", {31'd0, bus_a.Loading}, {31'd0, vecs[i].e_load});
      check("done",    {31'd0, bus_a.Done},    {31'd0, vecs[i].e_done});
      check("err",     {30'd0, bus_a.ErrCode}, {30'd0, vecs[i].e_err});
      check("count",   {21'd0, bus_a.Count},   {21'd0, vecs[i].e_count});
    end
    @(negedge clk);
    rst = 1'b0;
    bus_a.Start = 1'b0; bus_a.InValid = 1'b0;

    // Overflow on the 2-bit-address loader: four non-Ack words fill 0..3.
    cur_row = 1000;
    b_cycle(1'b1, 1'b0, 8'h00);
    check("b_loading", {31'd0, bus_b.Loading}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cur_row = 1000 + k;
      b_cycle(1'b0, 1'b1, 8'h00);
      check("b_wr_en_hi", {31'd0, bus_b.WrEn}, 32'd0);
      b_cycle(1'b0, 1'b1, 8'h10 + 8'(k));
      check("b_wr_en",   {31'd0, bus_b.WrEn},   32'd1);
      check("b_wr_addr", {30'd0, bus_b.WrAddr}, 32'(k));
      check("b_wr_data", {23'd0, bus_b.WrData}, 32'h10 + 32'(k));
      check("b_count",   {29'd0, bus_b.Count},  32'(k + 1));
      if (k < 3) begin
        check("b_err_mid", {30'd0, bus_b.ErrCode}, 32'd0);
      end else begin
        check("b_err_ovf", {30'd0, bus_b.ErrCode}, 32'd2);
        check("b_done",    {31'd0, bus_b.Done},    32'd0);
        check("b_load_end",{31'd0, bus_b.Loading}, 32'd0);
      end
    end
    cur_row = 1010;
    @(negedge clk);
    bus_b.InValid = 1'b1; bus_b.InByte = 8'h00;
    #1;
    check("b_ready_err", {31'd0, bus_b.InReady}, 32'd0);
    @(posedge clk);
    #1;
    check("b_wr_en_after", {31'd0, bus_b.WrEn},    32'd0);
    check("b_err_held",    {30'd0, bus_b.ErrCode}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
